// File: rtl/decode_hazard_unit.sv
// Decode-stage hazard unit: a scoreboard of in-flight destinations per downstream stage,
// generic operand forwarding and stall detection, plus the LL/SC reservation.
module decode_hazard_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int STG_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic                    id_valid,
  input  logic [REG_AW-1:0]       id_rs_addr,
  input  logic [REG_AW-1:0]       id_rt_addr,
  input  logic                    id_rs_used,
  input  logic                    id_rt_used,
  input  logic [DATA_W-1:0]       id_rs_rf,
  input  logic [DATA_W-1:0]       id_rt_rf,
  input  logic                    id_we,
  input  logic [REG_AW-1:0]       id_wr_addr,
  input  logic [STG_W-1:0]        id_ready_stage,
  input  logic                    id_ll,
  input  logic                    id_store,
  input  logic                    id_sc,
  input  logic                    exc,
  input  logic [DEPTH*DATA_W-1:0] stage_result,
  output logic [DATA_W-1:0]       rs_data,
  output logic [DATA_W-1:0]       rt_data,
  output logic [STG_W-1:0]        fwd_rs_stage,
  output logic [STG_W-1:0]        fwd_rt_stage,
  output logic                    stall,
  output logic                    atomic_id,
  output logic                    sc_mask_id
);

  logic              sb_valid [1:DEPTH];
  logic              sb_we    [1:DEPTH];
  logic [REG_AW-1:0] sb_addr  [1:DEPTH];
  logic [STG_W-1:0]  sb_ready [1:DEPTH];

  logic [STG_W-1:0]  new_ready;
  logic              rs_pending;
  logic              rt_pending;
  logic              atomic;
  logic              commit;

  assign new_ready = (id_ready_stage == '0) ? STG_W'(1) : id_ready_stage;

  // Walk from the oldest stage to the youngest so the youngest match overrides the rest.
  always_comb begin
    rs_data      = id_rs_rf;
    rt_data      = id_rt_rf;
    fwd_rs_stage = '0;
    fwd_rt_stage = '0;
    rs_pending   = 1'b0;
    rt_pending   = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (sb_valid[k] && sb_we[k] && (sb_addr[k] == id_rs_addr) && (id_rs_addr != '0)) begin
        if (STG_W'(k) >= sb_ready[k]) begin
          rs_data      = stage_result[k*DATA_W-1 -: DATA_W];
          fwd_rs_stage = STG_W'(k);
          rs_pending   = 1'b0;
        end else begin
          rs_data      = id_rs_rf;
          fwd_rs_stage = '0;
          rs_pending   = 1'b1;
        end
      end
      if (sb_valid[k] && sb_we[k] && (sb_addr[k] == id_rt_addr) && (id_rt_addr != '0)) begin
        if (STG_W'(k) >= sb_ready[k]) begin
          rt_data      = stage_result[k*DATA_W-1 -: DATA_W];
          fwd_rt_stage = STG_W'(k);
          rt_pending   = 1'b0;
        end else begin
          rt_data      = id_rt_rf;
          fwd_rt_stage = '0;
          rt_pending   = 1'b1;
        end
      end
    end
  end

  assign stall  = id_valid & ((id_rs_used & rs_pending) | (id_rt_used & rt_pending));
  assign commit = id_valid & ~stall & ~hold & ~exc;

  // A stalled or invalid decode slot enters stage 1 as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        sb_valid[k] <= 1'b0;
      end
    end else if (!hold) begin
      sb_valid[1] <= id_valid & ~stall;
      sb_we[1]    <= id_we;
      sb_addr[1]  <= id_wr_addr;
      sb_ready[1] <= new_ready;
      for (int k = 2; k <= DEPTH; k++) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_we[k]    <= sb_we[k-1];
        sb_addr[k]  <= sb_addr[k-1];
        sb_ready[k] <= sb_ready[k-1];
      end
    end
  end

  // Any store, including SC itself, drops the reservation.
  always_ff @(posedge clk) begin
    if (rst) begin
      atomic <= 1'b0;
    end else if (exc) begin
      atomic <= 1'b0;
    end else if (commit && id_store) begin
      atomic <= 1'b0;
    end else if (commit && id_ll) begin
      atomic <= 1'b1;
    end
  end

  assign atomic_id  = atomic;
  assign sc_mask_id = id_valid & id_sc & ~atomic;

endmodule

// File: doc/decode_hazard_unit.md
# decode_hazard_unit

Parametrised register-hazard and LL/SC tracking unit used by the decode stage. It keeps a scoreboard of in-flight destination registers, one entry per downstream pipeline stage. From that scoreboard it selects forwarded operands from any stage, stalls when a producer's result is not yet available, and keeps the load-linked reservation that drives `atomic_id` and `sc_mask_id`. It replaces fixed EX/MEM forwarding and load-use detection with a pipeline depth and per-instruction result latency that are set by parameters.

## Interface
- `DATA_W`, 32, operand width
- `REG_AW`, 5, register address width; address 0 is hard-wired zero
- `DEPTH`, 3, downstream stages tracked (stage 1 = EX … stage DEPTH)
- `STG_W`, $clog2(DEPTH+1), width of stage indices

- `clk` in 1: clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `hold` in 1: pipeline frozen this cycle
- `id_valid` in 1: decode holds a real instruction
- `id_rs_addr`, `id_rt_addr` in REG_AW: source registers
- `id_rs_used`, `id_rt_used` in 1: source actually read
- `id_rs_rf`, `id_rt_rf` in DATA_W: register-file read data
- `id_we` in 1: instruction writes a register
- `id_wr_addr` in REG_AW: destination register
- `id_ready_stage` in STG_W: first stage whose result bus carries the value
- `id_ll`, `id_store`, `id_sc` in 1: LL, any store (SW/SB/SH/SC), SC
- `exc` in 1: exception/eret; kills the reservation
- `stage_result` in DEPTH*DATA_W: slice [k*DATA_W-1 -: DATA_W] is the result of stage k
- `rs_data`, `rt_data` out DATA_W: resolved operands
- `fwd_rs_stage`, `fwd_rt_stage` out STG_W: source stage, 0 = register file
- `stall` out 1: hold decode, inject a bubble
- `atomic_id` out 1: LL reservation live
- `sc_mask_id` out 1: current SC must not store

## Operation
- Each scoreboard entry k (1..DEPTH) holds {valid, we, addr, ready}. It mirrors the instruction in stage k.
- Advance happens when `hold`=0:
  - Entry 1 loads {1, id_we, id_wr_addr, ready'} when id_valid & ~stall. Otherwise entry 1 loads a bubble (valid=0).
  - Entry k+1 loads entry k.
  - Entry DEPTH retires. The register file is write-before-read, so retired values come from `id_*_rf`.
- ready' = 1 if id_ready_stage==0, else id_ready_stage. A value > DEPTH means the result is never forwardable; the consumer waits for retirement.
- Operand match, per source s:
  - Find the smallest k with valid & we & addr==s & s!=0.
  - No match: data = rf input, fwd stage = 0.
  - Match with k ≥ ready: data = stage_result[k], fwd stage = k.
  - Match with k < ready: pending. Data = rf input (don't-care), fwd stage = 0.
- Only the youngest match counts. An older ready entry for the same register is never used.
- stall = id_valid & ((id_rs_used & rs_pending) | (id_rt_used & rt_pending)). Stall is computed regardless of `hold`.
- Reservation. A commit is a cycle with id_valid & ~stall & ~hold & ~exc. Priority order:
  1. rst → atomic = 0
  2. exc → 0
  3. commit & id_store → 0
  4. commit & id_ll → 1
- atomic_id = atomic register.
- sc_mask_id = id_valid & id_sc & ~atomic, evaluated from the pre-update state.
- An SC clears the reservation whether or not it succeeds.

## Timing
- All outputs other than the registers are combinational from the current state and ID inputs; ID-to-output latency is 0 cycles.
- Scoreboard and reservation update on the rising edge of `clk`. A commit is visible to the next instruction one cycle later.
- Reset values:
  - All entries valid=0.
  - atomic=0, so atomic_id=0.
  - With no ID inputs asserted: stall=0, fwd stages 0, rs/rt_data = rf inputs.
- Under `hold` the entries are frozen and reservation commits are suppressed. `exc` still clears the reservation.
- A stalled instruction re-evaluates every cycle. Its pending producer advances one stage per un-held cycle until k ≥ ready.
- Reset while entries are live: every entry is cleared next cycle, and no stall is raised afterwards.

## Test plan
- **Back-to-back ALU forward.** DEPTH=3. Issue `add $5` with ready=1, then `sub` reading $5 next cycle; stage 1 result = 0xDEADBEEF → rt_data=0xDEADBEEF, fwd_rt_stage=1, stall=0.
- **Load-use.**
  - Issue `lw $8` with ready=2, then a consumer of $8 in the next cycle → stall=1 for exactly one cycle.
  - Following cycle: fwd stage 2, data = stage 2 result. The bubble occupies entry 1.
- **Youngest wins.** `addi $3` (result 5) then `addi $3` (result 7), then a reader of $3 → rt_data=7 from stage 1, not 5 from stage 2.
- **$zero and unused source.**
  - A writer to $0 followed by a reader of $0 → rf data, no stall.
  - A pending $9 with id_rt_used=0 → stall=0.
- **Hold.** A load-use pair with hold=1 for 3 cycles → stall stays 1 and entries do not move. Release → stall clears after one more cycle.
- **LL/SC.**
  - LL then SC → sc_mask_id=0.
  - LL, SW, SC → sc_mask_id=1.
  - LL, exc, SC → sc_mask_id=1.
  - LL committed in the same cycle as exc → atomic_id stays 0.
